// File: rtl/ram_stream_pkg.sv
// Shared types and sizing for the RAM stream reader.
// Build option: define RAM_READ_REG_EN when the RAM has an output register.
// That gives a two-cycle read latency and a deeper buffer.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

`ifdef RAM_READ_REG_EN
    localparam int READ_LATENCY = 2;
`else
    localparam int READ_LATENCY = 1;
`endif

    // Two slots beyond the read latency keep reads flowing back to back
    // while still leaving room to absorb a stalled consumer.
    localparam int BUF_DEPTH = READ_LATENCY + 2;

    // Both the buffer occupancy and the in-flight count range over 0..BUF_DEPTH.
    localparam int CNT_WIDTH = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_skid_fifo.sv
// Small circular buffer that sits in front of the output stream.
// The head entry is presented directly, so stream data comes straight from storage registers.
// At most one push and one pop are made per cycle.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module stream_skid_fifo #(
    parameter int WIDTH     = 9,
    parameter int DEPTH     = 3,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic                 head_valid,
    output logic [CNT_WIDTH-1:0] occupancy
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic                 do_push;
    logic                 do_pop;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign do_pop     = pop && (occupancy != '0);
    assign do_push    = push && ((occupancy != CNT_WIDTH'(DEPTH)) || do_pop);
    assign head_data  = mem[rd_ptr];
    assign head_valid = (occupancy != '0);

    // Storage, pointers and occupancy.
    // Storage is cleared on reset so the exposed head reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a run of consecutive RAM words and replays them as a valid/ready stream with a last marker.
// Reads are paced by credits: a read is issued only when its word is guaranteed a buffer slot.
// Words already buffered, words still inside the RAM pipeline, and a beat leaving this cycle
// are all counted against the buffer depth.
// Build option RAM_READ_REG_EN selects the two-cycle RAM read latency (see ram_stream_pkg).
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_write_enable,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [LEN_WIDTH-1:0]    remaining;
    logic [READ_LATENCY:0]   pipe_valid;
    logic [READ_LATENCY:0]   pipe_last;
    logic [CNT_WIDTH-1:0]    inflight;
    logic [CNT_WIDTH-1:0]    occupancy;
    logic [CNT_WIDTH:0]      credit_used;
    logic [DATA_WIDTH:0]     head;
    logic                    head_valid;
    logic                    accept;
    logic                    can_issue;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    done_d;

    assign ram_write_enable = 1'b0;
    assign ram_data_in      = '0;

    assign out_valid = head_valid;
    assign out_data  = head[DATA_WIDTH-1:0];
    assign out_last  = head[DATA_WIDTH] && head_valid;

    assign pop    = out_valid && out_ready;
    assign push   = pipe_valid[READ_LATENCY];
    assign accept = (state_q == IDLE) && start && (length != '0);

    // A beat leaving this cycle frees its slot in time for a read issued now.
    assign credit_used = {1'b0, occupancy} + {1'b0, inflight} - {{CNT_WIDTH{1'b0}}, pop};
    assign can_issue   = credit_used < (CNT_WIDTH + 1)'(BUF_DEPTH);

    stream_skid_fifo #(
        .WIDTH     (DATA_WIDTH + 1),
        .DEPTH     (BUF_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({pipe_last[READ_LATENCY], ram_data_out}),
        .pop       (pop),
        .head_data (head),
        .head_valid(head_valid),
        .occupancy (occupancy)
    );

    // Next state and read issue.
    // The transfer ends on the handshake of the final beat; by then nothing remains in flight.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (remaining == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus the registered busy and done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= done_d;
        end
    end

    // Address generation, the remaining count, and the RAM latency shadow.
    // The shadow tags each read so its word is pushed into the buffer the cycle it appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr   <= '0;
            remaining  <= '0;
            ram_addr   <= '0;
            pipe_valid <= '0;
            pipe_last  <= '0;
            inflight   <= '0;
        end else begin
            if (accept) begin
                cur_addr  <= base_addr;
                remaining <= length;
            end else if (issue) begin
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (issue) begin
                ram_addr <= cur_addr;
            end
            pipe_valid <= {pipe_valid[READ_LATENCY-1:0], issue};
            pipe_last  <= {pipe_last[READ_LATENCY-1:0], issue && (remaining == LEN_WIDTH'(1))};
            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a scoreboard of expected beats.
// It also contains a RAM model whose read latency follows RAM_READ_REG_EN.
module tb_ram_stream_reader;

`ifdef RAM_READ_REG_EN
    localparam int EXP_LAT   = 4;
    localparam int EXP_DEPTH = 4;
`else
    localparam int EXP_LAT   = 3;
    localparam int EXP_DEPTH = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] length;
    logic        busy;
    logic        done;
    logic [11:0] ram_addr;
    logic        ram_write_enable;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int          total = 0;
    int          bad   = 0;
    int          beats = 0;
    logic [8:0]  sb_q[$];

    logic [7:0]  mem [4096];
    logic [7:0]  ram_q1;
    logic [7:0]  ram_q2;

    always #5 clk = ~clk;

    ram_stream_reader dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .base_addr       (base_addr),
        .length          (length),
        .busy            (busy),
        .done            (done),
        .ram_addr        (ram_addr),
        .ram_write_enable(ram_write_enable),
        .ram_data_in     (ram_data_in),
        .ram_data_out    (ram_data_out),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last)
    );

    // RAM read port with one or two registered stages.
    always @(posedge clk) begin
        ram_q1 <= mem[ram_addr];
        ram_q2 <= ram_q1;
    end

`ifdef RAM_READ_REG_EN
    assign ram_data_out = ram_q2;
`else
    assign ram_data_out = ram_q1;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle start. Called at posedge+1 and returns at posedge+1 after the sampling edge.
    task automatic applyStimulus(input logic [11:0] base, input logic [12:0] len, input bit expect_accept);
        logic [11:0] addr;
        start     = 1'b1;
        base_addr = base;
        length    = len;
        if (expect_accept) begin
            for (int k = 0; k < int'(len); k++) begin
                addr = base + 12'(k);
                sb_q.push_back({1'(k == int'(len) - 1), addr[7:0]});
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Follows a transfer edge by edge, counting from the edge that sampled start.
    task automatic waitDone(input string tag, input bit exp_busy, input int exp_valid_edge,
                            input int exp_done_edge, input bit random_ready);
        int edge_n      = 0;
        int first_valid = -1;
        int done_edge   = -1;
        bit busy_ok     = 1'b1;
        while (edge_n < 600) begin
            if (out_valid && first_valid < 0) first_valid = edge_n;
            if (done) begin
                done_edge = edge_n;
                break;
            end
            if (busy !== exp_busy) busy_ok = 1'b0;
            if (random_ready) begin
                if ((edge_n % 14) >= 4 && (edge_n % 14) < 9) out_ready = 1'b0;
                else out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            edge_n++;
        end
        checkOutput({tag, "_done_seen"}, 32'(done_edge >= 0), 32'd1);
        if (exp_done_edge >= 0) checkOutput({tag, "_done_edge"}, 32'(done_edge), 32'(exp_done_edge));
        checkOutput({tag, "_first_valid"}, 32'(first_valid), 32'(exp_valid_edge));
        checkOutput({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        checkOutput({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    // Stream monitor: scoreboard comparison, stall stability and buffer bound.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_last  = 1'b0;
    logic       prev_reset = 1'b1;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        logic [8:0] exp_beat;
        if (!reset && !prev_reset && prev_valid && !prev_ready) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_data", 32'(out_data), 32'(prev_data));
            checkOutput("stall_last", 32'(out_last), 32'(prev_last));
        end
        if (!reset && busy) begin
            checkOutput("occupancy_bound", 32'(int'(dut.u_fifo.occupancy) <= EXP_DEPTH), 32'd1);
        end
        if (!reset && out_valid && out_ready) begin
            checkOutput("beat_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_beat = sb_q.pop_front();
                checkOutput("beat_data", 32'(out_data), 32'(exp_beat[7:0]));
                checkOutput("beat_last", 32'(out_last), 32'(exp_beat[8]));
            end
            beats++;
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_last  = out_last;
        prev_data  = out_data;
        prev_reset = reset;
    end

    initial begin
        int n;
        int beats0;
        bit done_seen;

        for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_last", 32'(out_last), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("rst_addr", 32'(ram_addr), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] basic transfer base=0x010 len=8");
        applyStimulus(12'h010, 13'd8, 1'b1);
        checkOutput("write_enable", 32'(ram_write_enable), 32'd0);
        checkOutput("write_data", 32'(ram_data_in), 32'd0);
        waitDone("basic", 1'b1, EXP_LAT, EXP_LAT + 8, 1'b0);

        $display("[TB] zero length");
        applyStimulus(12'h020, 13'd0, 1'b0);
        waitDone("len0", 1'b0, -1, 0, 1'b0);

        $display("[TB] address wrap base=0xFFE len=4");
        applyStimulus(12'hFFE, 13'd4, 1'b1);
        waitDone("wrap", 1'b1, EXP_LAT, EXP_LAT + 4, 1'b0);
        checkOutput("wrap_last_addr", 32'(ram_addr), 32'h001);

        $display("[TB] backpressure len=16");
        applyStimulus(12'h0A0, 13'd16, 1'b1);
        waitDone("stall", 1'b1, EXP_LAT, -1, 1'b1);

        $display("[TB] ignored start then reset mid-transfer");
        beats0 = beats;
        applyStimulus(12'h120, 13'd12, 1'b1);
        applyStimulus(12'h340, 13'd5, 1'b0);
        checkOutput("ignored_start_busy", 32'(busy), 32'd1);
        n = 0;
        while (beats < beats0 + 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("three_beats_seen", 32'(beats - beats0), 32'd3);
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_last", 32'(out_last), 32'd0);
        checkOutput("abort_data", 32'(out_data), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_addr", 32'(ram_addr), 32'd0);
        sb_q.delete();
        reset     = 1'b0;
        out_ready = 1'b1;
        done_seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done || out_valid) done_seen = 1'b1;
        end
        checkOutput("abort_quiet", 32'(done_seen), 32'd0);

        $display("[TB] transfer after reset base=0x050 len=5");
        applyStimulus(12'h050, 13'd5, 1'b1);
        waitDone("after_reset", 1'b1, EXP_LAT, EXP_LAT + 5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
